// File: rtl/space_inv_pkg.sv
// space_inv_pkg
// Shared types and constants for the player ship lifecycle controller.
//   ship_state_t : lifecycle states of the player ship
//   DEF_*        : default frame counts used as module parameter defaults
//   LIVES_W      : width of the lives counter
//   CNT_W        : width of every frame-based down counter
//   blink_bit()  : picks one counter bit as a blink phase for the draw enable
package space_inv_pkg;

    localparam int LIVES_W = 3;
    localparam int CNT_W   = 8;

    localparam int DEF_LIVES          = 3;
    localparam int DEF_BLINK_FRAMES   = 60;
    localparam int DEF_RESPAWN_FRAMES = 30;
    localparam int DEF_FIRE_COOLDOWN  = 15;
    localparam int DEF_INVULN_FRAMES  = 90;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIVE,
        ST_HIT,
        ST_RESPAWN,
        ST_OVER
    } ship_state_t;

    // A counter bit toggling every 2^sel frames gives a cheap blink phase.
    function automatic logic blink_bit(input logic [CNT_W-1:0] cnt,
                                       input logic [2:0]       sel);
        return cnt[sel];
    endfunction

endpackage

// File: rtl/player_ship_ctrl_frame_down_counter.sv
// frame_down_counter
// Loadable down counter that steps once per video frame and stops at zero.
// Ports:
//   clk, resetN   : clock, asynchronous active-low reset (count -> 0)
//   startOfFrame  : one-clk frame pulse, enables one decrement
//   clear         : synchronous force to zero (highest priority)
//   load, loadVal : synchronous load (beats the frame decrement)
//   cnt           : current count
//   zero          : cnt == 0
module frame_down_counter
    import space_inv_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Clear beats load beats decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (startOfFrame && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/player_ship_ctrl.sv
// player_ship_ctrl
// Lifecycle controller for the player ship: gates the mover keys, sequences
// hit / blink / respawn, counts lives and rate-limits fire requests.
// Optional build macro INVULN_EN adds post-respawn invulnerability.
// Ports:
//   clk, resetN      : clock, asynchronous active-low reset
//   startOfFrame     : one-clk pulse per video frame
//   startGame        : level, starts a game from idle or game over
//   btnRight/Left    : movement key levels
//   btnFire          : fire key level
//   playerHit        : collision of the ship with an enemy shot/alien
//   RightMove/LeftMove : movement enables to the ship mover
//   respawnPulse     : one-clk pulse, mover reloads its start position
//   shipVisible      : draw enable for the ship
//   fireReq          : one-clk request to the shot generator
//   livesLeft        : remaining lives
//   gameOver         : high while the game is over
module player_ship_ctrl
    import space_inv_pkg::*;
#(
    parameter int LIVES          = DEF_LIVES,
    parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int FIRE_COOLDOWN  = DEF_FIRE_COOLDOWN
`ifdef INVULN_EN
   ,parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES
`endif
)(
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       btnRight,
    input  logic       btnLeft,
    input  logic       btnFire,
    input  logic       playerHit,
    output logic       RightMove,
    output logic       LeftMove,
    output logic       respawnPulse,
    output logic       shipVisible,
    output logic       fireReq,
    output logic [2:0] livesLeft,
    output logic       gameOver
);

    localparam logic [LIVES_W-1:0] LIVES_LD   = LIVES_W'(LIVES);
    localparam logic [CNT_W-1:0]   BLINK_LD   = CNT_W'(BLINK_FRAMES);
    localparam logic [CNT_W-1:0]   RESPAWN_LD = CNT_W'(RESPAWN_FRAMES);
    localparam logic [CNT_W-1:0]   COOL_LD    = CNT_W'(FIRE_COOLDOWN);

    ship_state_t      state, stateNext;
    logic [CNT_W-1:0] frmCnt, frmLoadVal, coolCnt;
    logic             frmZero, frmLoad, coolZero, coolReady;
    logic             startNow, respawnNow, hitAccept, fireAccept;
    logic             invulnActive, invulnBlink;

    frame_down_counter uFrame (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .clear        (1'b0),
        .load         (frmLoad),
        .loadVal      (frmLoadVal),
        .cnt          (frmCnt),
        .zero         (frmZero)
    );

    // Cooldown restarts from zero whenever the ship (re)enters play.
    frame_down_counter uCool (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .clear        (startNow | respawnNow),
        .load         (fireAccept),
        .loadVal      (COOL_LD),
        .cnt          (coolCnt),
        .zero         (coolZero)
    );

    // The accepting frame's own decrement is folded into the ready check, so
    // accepted shots land exactly FIRE_COOLDOWN frames apart.
    assign coolReady = coolZero | (coolCnt == CNT_W'(1));

`ifdef INVULN_EN
    logic [CNT_W-1:0] invulnCnt;
    logic             invulnZero;

    // Only a respawn grants invulnerability; a fresh game start wipes it.
    frame_down_counter uInvuln (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .clear        (startNow),
        .load         (respawnNow),
        .loadVal      (CNT_W'(INVULN_FRAMES)),
        .cnt          (invulnCnt),
        .zero         (invulnZero)
    );

    assign invulnActive = ~invulnZero;
    assign invulnBlink  = blink_bit(invulnCnt, 3'd1);
`else
    assign invulnActive = 1'b0;
    assign invulnBlink  = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus the one-cycle strobes that steer the counters.
    // A hit is checked every clock and takes precedence over a fire request.
    always_comb begin
        stateNext  = state;
        startNow   = 1'b0;
        respawnNow = 1'b0;
        hitAccept  = 1'b0;
        fireAccept = 1'b0;
        frmLoad    = 1'b0;
        frmLoadVal = BLINK_LD;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (startGame) begin
                    startNow  = 1'b1;
                    stateNext = ST_ALIVE;
                end
            end
            ST_ALIVE: begin
                if (playerHit && !invulnActive) begin
                    hitAccept  = 1'b1;
                    frmLoad    = 1'b1;
                    frmLoadVal = BLINK_LD;
                    stateNext  = ST_HIT;
                end else if (startOfFrame && btnFire && coolReady) begin
                    fireAccept = 1'b1;
                end
            end
            ST_HIT: begin
                if (frmZero) begin
                    if (livesLeft == '0) begin
                        stateNext = ST_OVER;
                    end else begin
                        frmLoad    = 1'b1;
                        frmLoadVal = RESPAWN_LD;
                        stateNext  = ST_RESPAWN;
                    end
                end
            end
            ST_RESPAWN: begin
                if (frmZero) begin
                    respawnNow = 1'b1;
                    stateNext  = ST_ALIVE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Registered pulses and the lives counter; a hit can only be accepted
    // with at least one life left, so the decrement never wraps.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            livesLeft    <= LIVES_LD;
            respawnPulse <= 1'b0;
            fireReq      <= 1'b0;
        end else begin
            respawnPulse <= startNow | respawnNow;
            fireReq      <= fireAccept;
            if (startNow) begin
                livesLeft <= LIVES_LD;
            end else if (hitAccept && (livesLeft != '0)) begin
                livesLeft <= livesLeft - LIVES_W'(1);
            end
        end
    end

    // Movement enables, draw enable and game-over flag decoded from state.
    always_comb begin
        RightMove   = 1'b0;
        LeftMove    = 1'b0;
        shipVisible = 1'b0;
        case (state)
            ST_ALIVE: begin
                RightMove   = btnRight & ~btnLeft;
                LeftMove    = btnLeft & ~btnRight;
                shipVisible = invulnActive ? invulnBlink : 1'b1;
            end
            ST_HIT:  shipVisible = blink_bit(frmCnt, 3'd2);
            default: shipVisible = 1'b0;
        endcase
    end

    assign gameOver = (state == ST_OVER);

endmodule
